// File: rtl/idu_fetch_rx.sv
// IFU->IDU fetch receiver: DEPTH-entry packet buffer with combinational RV32I field decode of the head entry.
// Define IDU_PERF_CNT_EN to add the perf_accept / perf_ifu_stall / perf_exu_stall counter ports.
module idu_fetch_rx #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifu_valid,
    input  logic [2*WIDTH-1:0] ifu_data,
    output logic               idu_ready,
    input  logic               flush,
    output logic               exu_valid,
    input  logic               exu_ready,
    output logic [WIDTH-1:0]   exu_pc,
    output logic [WIDTH-1:0]   exu_inst,
    output logic [2:0]         exu_type,
    output logic [4:0]         exu_rd,
    output logic [4:0]         exu_rs1,
    output logic [4:0]         exu_rs2,
    output logic [WIDTH-1:0]   exu_imm
`ifdef IDU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_accept,
    output logic [31:0]        perf_ifu_stall,
    output logic [31:0]        perf_exu_stall
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [2:0] T_R   = 3'd0;
    localparam logic [2:0] T_I   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_B   = 3'd3;
    localparam logic [2:0] T_U   = 3'd4;
    localparam logic [2:0] T_J   = 3'd5;
    localparam logic [2:0] T_ILL = 3'd7;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   inst;

    // Handshake flags depend only on the registered count.
    assign idu_ready = (count != CW'(DEPTH));
    assign exu_valid = (count != CW'(0));
    assign push      = ifu_valid & idu_ready & ~flush;
    assign pop       = exu_valid & exu_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ifu_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign inst     = mem[rd_ptr][2*WIDTH-1:WIDTH];
    assign exu_inst = inst;
    assign exu_pc   = mem[rd_ptr][WIDTH-1:0];
    assign exu_rd   = inst[11:7];
    assign exu_rs1  = inst[19:15];
    assign exu_rs2  = inst[24:20];

    // Format classification and sign-extended immediate of the head entry.
    always_comb begin
        exu_type = T_ILL;
        exu_imm  = '0;
        case (inst[6:0])
            7'b0110011: exu_type = T_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                exu_type = T_I;
                exu_imm  = {{(WIDTH-12){inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                exu_type = T_S;
                exu_imm  = {{(WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                exu_type = T_B;
                exu_imm  = {{(WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                exu_type = T_U;
                exu_imm  = {{(WIDTH-32){inst[31]}}, inst[31:12], 12'b0};
            end
            7'b1101111: begin
                exu_type = T_J;
                exu_imm  = {{(WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                exu_type = T_ILL;
                exu_imm  = '0;
            end
        endcase
    end

`ifdef IDU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_accept    <= '0;
            perf_ifu_stall <= '0;
            perf_exu_stall <= '0;
        end else begin
            if (push) begin
                perf_accept <= perf_accept + 32'd1;
            end
            if (ifu_valid && !idu_ready) begin
                perf_ifu_stall <= perf_ifu_stall + 32'd1;
            end
            if (exu_valid && !exu_ready) begin
                perf_exu_stall <= perf_exu_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/idu_fetch_rx.md
Name: idu_fetch_rx

Overview:
- Receiving end of the IFU→IDU fetch handshake.
- Accepts {inst, pc} packets on a valid/ready interface into a 2-entry buffer.
- Decodes the head entry's RV32I fields and presents them to the EXU on a second valid/ready interface.
- Decouples IFU back-pressure from EXU stalls and supports pipeline flush on redirect.

Parameters:
- WIDTH, 32, PC and instruction width in bits; the packet is 2*WIDTH wide.
- DEPTH, 2, buffer entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- ifu_valid  in  1  fetch packet valid
- ifu_data  in  2*WIDTH  packet; [2*WIDTH-1:WIDTH]=inst, [WIDTH-1:0]=pc
- idu_ready  out  1  buffer can accept a packet
- flush  in  1  discard all buffered and incoming packets
- exu_valid  out  1  decoded head entry valid
- exu_ready  in  1  EXU consumes the head entry
- exu_pc  out  WIDTH  head entry PC
- exu_inst  out  WIDTH  head entry instruction
- exu_type  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- exu_rd  out  5  inst[11:7]
- exu_rs1  out  5  inst[19:15]
- exu_rs2  out  5  inst[24:20]
- exu_imm  out  WIDTH  sign-extended immediate; 0 for R and illegal

Behaviour:
- Storage: circular buffer of DEPTH entries. Write pointer, read pointer and a count register sized 0..DEPTH.
- Reset (rst=0, asynchronous): pointers=0, count=0, entries=0. Resulting outputs: exu_valid=0, idu_ready=1, data outputs decode all-zero.
- idu_ready = (count != DEPTH). It is driven only from registered state; there is no combinational path from exu_ready.
- Push: ifu_valid & idu_ready & !flush.
- Pop: exu_valid & exu_ready & !flush.
- exu_valid = (count != 0).
- Latency: a packet pushed at edge N is visible at the outputs after edge N. There is no same-cycle bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, push cannot occur in that cycle because idu_ready is registered low.
- Output hold: while exu_valid=1 and exu_ready=0, all exu_* outputs stay stable.
- Flush: on the edge where flush=1, count and pointers go to 0. Any push or pop in that cycle is ignored. Entry contents are not cleared.
- Decode is combinational from the head entry (opcode = inst[6:0]):
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - anything else → illegal
- Immediates use standard RV32I packing, sign-extended from inst[31]:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- rd, rs1 and rs2 are always the raw bit fields, whatever the format.
- Pointer wrap: modulo DEPTH.
- Reset during operation drops all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro: IDU_PERF_CNT_EN.
- When defined, three 32-bit output ports are added, all reset to 0 and all wrapping at 2^32:
  - perf_accept: counts pushes.
  - perf_ifu_stall: counts cycles with ifu_valid=1 and idu_ready=0.
  - perf_exu_stall: counts cycles with exu_valid=1 and exu_ready=0.
- When undefined, these ports and the counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then push inst=0x00500093, pc=0x80000000 with exu_ready=1. Next cycle: exu_valid=1, type=1, rd=1, rs1=0, imm=0x00000005. Popped the following edge.
- With exu_ready=0, push 0x0080006F, then 0x00112623. Expected: idu_ready=0 after the second push, and ifu_valid is held without being accepted. Output is J with imm=0x00000008. After one pop, the next output is S with rs1=2, rs2=1, imm=0x0000000C, and idu_ready=1.
- Push 0xFE000EE3 → type=3, rs1=0, rs2=0, imm=0xFFFFFFFC. Push 0x00000000 → type=7, imm=0.
- Fill to 2 entries, then assert flush together with ifu_valid=1. Next cycle: exu_valid=0, idu_ready=1, and the packet offered in the flush cycle is absent.
- Continuous stream with exu_ready=1 and ifu_valid=1: one packet per cycle in order, with count steady at 1 (simultaneous push/pop).
- Assert rst=0 asynchronously between edges while holding an entry: exu_valid drops to 0 before the next clock edge.
